// File: rtl/conv_pkg.sv
// Shared types and default constants for the convolution controller.
// Holds the FSM state encoding and a width helper used for counter sizing.
package conv_pkg;

  localparam int DEF_NUM_FILT  = 4;
  localparam int DEF_FILT_LEN  = 4;
  localparam int DEF_LINE_LEN  = 16;
  localparam int DEF_NUM_LINES = 4;
  localparam int DEF_STRIDE    = 1;
  localparam int DEF_OUT_ROWS  = 16;
  localparam int DEF_PACK      = 4;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE, INIT, LD_FILT, NXT_FILT, LD_MAIN, SHF_MAIN, LD_WIN, CONV,
    PUSH, DECIDE, WR_MEM, ROW_CHK, LD_LINE, FLUSH, DONE
  } state_t;

  // Counter width for a modulus n; never narrower than one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_ctrl_gen2_if.sv
// Memory request/accept bus plus address-register strobes between the
// convolution controller (master) and the memory/address datapath (slave).
interface conv_ctrl_gen2_if;
  logic mem_rd;
  logic mem_wr;
  logic mem_ready;
  logic mem_addr_sel;
  logic addr_init;
  logic addr_inc_img;
  logic addr_inc_filt;
  logic addr_inc_out;

  modport master (
    output mem_rd, mem_wr, mem_addr_sel,
    output addr_init, addr_inc_img, addr_inc_filt, addr_inc_out,
    input  mem_ready
  );

  modport slave (
    input  mem_rd, mem_wr, mem_addr_sel,
    input  addr_init, addr_inc_img, addr_inc_filt, addr_inc_out,
    output mem_ready
  );
endinterface

// File: rtl/mod_counter.sv
// Modulo-MOD up counter: counts on en, wraps to zero after MOD-1,
// with synchronous clear and active-low synchronous reset.
module mod_counter
  import conv_pkg::*;
#(
  parameter int MOD = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  output logic [cw(MOD)-1:0] count,
  output logic              last
);

  localparam int            W   = cw(MOD);
  localparam logic [W-1:0]  MAX = W'(MOD - 1);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= last ? '0 : count_reg + W'(1);
    end
  end

  assign count = count_reg;
  assign last  = (count_reg == MAX);

endmodule

// File: rtl/conv_ctrl_gen2.sv
// Convolution sequencing controller: loads filters and image lines, walks
// windows across each row, runs every filter per window and packs results.
module conv_ctrl_gen2
  import conv_pkg::*;
#(
  parameter int NUM_FILT  = DEF_NUM_FILT,
  parameter int FILT_LEN  = DEF_FILT_LEN,
  parameter int LINE_LEN  = DEF_LINE_LEN,
  parameter int NUM_LINES = DEF_NUM_LINES,
  parameter int STRIDE    = DEF_STRIDE,
  parameter int OUT_ROWS  = DEF_OUT_ROWS,
  parameter int PACK      = DEF_PACK
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  conv_ctrl_gen2_if.master         mem,
  output logic [NUM_FILT-1:0]      filt_wr_en,
  output logic [cw(NUM_FILT)-1:0]  filt_idx,
  output logic [cw(FILT_LEN)-1:0]  word_idx,
  output logic                     main_wr_en,
  output logic                     main_shift_en,
  output logic                     win_load_en,
  output logic                     mac_en,
  output logic                     mac_clr,
  output logic                     psum_push,
  output logic                     flush,
  output logic                     busy,
  output logic                     done
);

  localparam int WIN_PER_ROW = (LINE_LEN - FILT_LEN) / STRIDE + 1;
  localparam int FW = cw(NUM_FILT);
  localparam int WW = cw(FILT_LEN);

  state_t state_reg, state_next;

  logic [WW-1:0]                    word_cnt;
  logic [FW-1:0]                    filt_cnt;
  logic [cw(LINE_LEN)-1:0]          col_cnt;
  logic [cw(NUM_LINES+1)-1:0]       line_cnt;
  logic [cw(WIN_PER_ROW)-1:0]       win_cnt;
  logic [cw(PACK+1)-1:0]            pack_cnt;
  logic [cw(OUT_ROWS)-1:0]          row_cnt;
  logic word_last, filt_last, col_last, line_full, win_last, pack_full, row_last;
  logic word_en, filt_en, col_en, line_en, win_en, win_clr, pack_en, pack_clr, row_en;
  logic clr_all;
  logic unused_cnt_bits;

  assign clr_all         = (state_reg == IDLE);
  assign unused_cnt_bits = ^{col_cnt, line_cnt, row_cnt};

  mod_counter #(.MOD(FILT_LEN)) u_word (
    .clk(clk), .rst(rst), .en(word_en), .clr(clr_all),
    .count(word_cnt), .last(word_last));
  mod_counter #(.MOD(NUM_FILT)) u_filt (
    .clk(clk), .rst(rst), .en(filt_en), .clr(clr_all),
    .count(filt_cnt), .last(filt_last));
  mod_counter #(.MOD(LINE_LEN)) u_col (
    .clk(clk), .rst(rst), .en(col_en), .clr(clr_all),
    .count(col_cnt), .last(col_last));
  // Modulus NUM_LINES+1 so "all lines loaded" is a distinct count value.
  mod_counter #(.MOD(NUM_LINES + 1)) u_line (
    .clk(clk), .rst(rst), .en(line_en), .clr(clr_all),
    .count(line_cnt), .last(line_full));
  mod_counter #(.MOD(WIN_PER_ROW)) u_win (
    .clk(clk), .rst(rst), .en(win_en), .clr(clr_all | win_clr),
    .count(win_cnt), .last(win_last));
  mod_counter #(.MOD(PACK + 1)) u_pack (
    .clk(clk), .rst(rst), .en(pack_en), .clr(clr_all | pack_clr),
    .count(pack_cnt), .last(pack_full));
  mod_counter #(.MOD(OUT_ROWS)) u_row (
    .clk(clk), .rst(rst), .en(row_en), .clr(clr_all),
    .count(row_cnt), .last(row_last));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // After DECIDE the filter index has already advanced, so filt_cnt==0 in
  // WR_MEM means the window is complete and win_cnt==0 means the row is.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:     if (start) state_next = INIT;
      INIT:     if (!start) state_next = LD_FILT;
      LD_FILT:  if (mem.mem_ready && word_last) state_next = NXT_FILT;
      NXT_FILT: state_next = filt_last ? LD_MAIN : LD_FILT;
      LD_MAIN:  if (mem.mem_ready && col_last) state_next = SHF_MAIN;
      SHF_MAIN: state_next = line_full ? LD_WIN : LD_MAIN;
      LD_WIN:   state_next = CONV;
      CONV:     if (word_last) state_next = PUSH;
      PUSH:     state_next = DECIDE;
      DECIDE: begin
        if (pack_full)       state_next = WR_MEM;
        else if (!filt_last) state_next = CONV;
        else if (win_last)   state_next = ROW_CHK;
        else                 state_next = LD_WIN;
      end
      WR_MEM: begin
        if (mem.mem_ready) begin
          if (filt_cnt != '0)     state_next = CONV;
          else if (win_cnt == '0) state_next = ROW_CHK;
          else                    state_next = LD_WIN;
        end
      end
      ROW_CHK:  state_next = row_last ? FLUSH : LD_LINE;
      LD_LINE:  if (mem.mem_ready && col_last) state_next = LD_WIN;
      FLUSH:    if (pack_cnt == '0 || mem.mem_ready) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    mem.mem_rd        = 1'b0;
    mem.mem_wr        = 1'b0;
    mem.mem_addr_sel  = 1'b0;
    mem.addr_init     = 1'b0;
    mem.addr_inc_img  = 1'b0;
    mem.addr_inc_filt = 1'b0;
    mem.addr_inc_out  = 1'b0;
    filt_wr_en        = '0;
    main_wr_en        = 1'b0;
    main_shift_en     = 1'b0;
    win_load_en       = 1'b0;
    mac_en            = 1'b0;
    mac_clr           = 1'b0;
    psum_push         = 1'b0;
    flush             = 1'b0;
    done              = 1'b0;
    word_en           = 1'b0;
    filt_en           = 1'b0;
    col_en            = 1'b0;
    line_en           = 1'b0;
    win_en            = 1'b0;
    win_clr           = 1'b0;
    pack_en           = 1'b0;
    pack_clr          = 1'b0;
    row_en            = 1'b0;
    unique case (state_reg)
      INIT: mem.addr_init = !start;
      LD_FILT: begin
        mem.mem_rd       = 1'b1;
        mem.mem_addr_sel = 1'b1;
        if (mem.mem_ready) begin
          for (int i = 0; i < NUM_FILT; i++) begin
            filt_wr_en[i] = (filt_cnt == FW'(i));
          end
          mem.addr_inc_filt = 1'b1;
          word_en           = 1'b1;
        end
      end
      NXT_FILT: filt_en = 1'b1;
      LD_MAIN, LD_LINE: begin
        mem.mem_rd = 1'b1;
        if (mem.mem_ready) begin
          main_wr_en       = 1'b1;
          mem.addr_inc_img = 1'b1;
          col_en           = 1'b1;
          line_en          = (state_reg == LD_MAIN) && col_last;
        end
      end
      SHF_MAIN: main_shift_en = !line_full;
      LD_WIN:   win_load_en = 1'b1;
      CONV: begin
        mac_en  = 1'b1;
        word_en = 1'b1;
      end
      PUSH: begin
        psum_push = 1'b1;
        pack_en   = 1'b1;
      end
      DECIDE: begin
        mac_clr = 1'b1;
        filt_en = 1'b1;
        win_en  = filt_last;
      end
      WR_MEM: begin
        mem.mem_wr = 1'b1;
        if (mem.mem_ready) begin
          mem.addr_inc_out = 1'b1;
          pack_clr         = 1'b1;
        end
      end
      ROW_CHK: begin
        row_en        = 1'b1;
        main_shift_en = !row_last;
        win_clr       = !row_last;
      end
      FLUSH: begin
        if (pack_cnt != '0) begin
          flush      = 1'b1;
          mem.mem_wr = 1'b1;
          if (mem.mem_ready) begin
            mem.addr_inc_out = 1'b1;
            pack_clr         = 1'b1;
          end
        end
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign filt_idx = filt_cnt;
  assign word_idx = word_cnt;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_conv_ctrl_gen2.sv
// Randomized self-checking bench: two controller instances (default and
// stride-2/pack-3/one-row) compared against arithmetic job-level expectations.
module tb_conv_ctrl_gen2;
  import conv_pkg::*;

  localparam int NF = 4;
  localparam int FL = 4;
  localparam int LL = 16;
  localparam int NL = 4;
  localparam int B_STRIDE = 2;
  localparam int B_PACK   = 3;
  localparam int B_ROWS   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_a, start_b;
  logic sel;

  conv_ctrl_gen2_if if_a ();
  conv_ctrl_gen2_if if_b ();

  logic [NF-1:0]        fwe_a, fwe_b;
  logic [cw(NF)-1:0]    fidx_a, fidx_b;
  logic [cw(FL)-1:0]    widx_a, widx_b;
  logic mwe_a, msh_a, wle_a, mac_a, mclr_a, push_a, fl_a, busy_a, done_a;
  logic mwe_b, msh_b, wle_b, mac_b, mclr_b, push_b, fl_b, busy_b, done_b;

  conv_ctrl_gen2 dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mem(if_a),
    .filt_wr_en(fwe_a), .filt_idx(fidx_a), .word_idx(widx_a),
    .main_wr_en(mwe_a), .main_shift_en(msh_a), .win_load_en(wle_a),
    .mac_en(mac_a), .mac_clr(mclr_a), .psum_push(push_a), .flush(fl_a),
    .busy(busy_a), .done(done_a));

  conv_ctrl_gen2 #(.STRIDE(B_STRIDE), .PACK(B_PACK), .OUT_ROWS(B_ROWS)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mem(if_b),
    .filt_wr_en(fwe_b), .filt_idx(fidx_b), .word_idx(widx_b),
    .main_wr_en(mwe_b), .main_shift_en(msh_b), .win_load_en(wle_b),
    .mac_en(mac_b), .mac_clr(mclr_b), .psum_push(push_b), .flush(fl_b),
    .busy(busy_b), .done(done_b));

  typedef struct packed {
    logic rd, wr, asel, ainit, inc_img, inc_filt, inc_out;
    logic [NF-1:0]     fwe;
    logic [cw(NF)-1:0] fidx;
    logic [cw(FL)-1:0] widx;
    logic mwe, msh, wle, mac, mclr, push, fl, busy, done;
  } obs_t;

  obs_t obs_a, obs_b, o;

  assign obs_a = {if_a.mem_rd, if_a.mem_wr, if_a.mem_addr_sel, if_a.addr_init,
                  if_a.addr_inc_img, if_a.addr_inc_filt, if_a.addr_inc_out,
                  fwe_a, fidx_a, widx_a,
                  mwe_a, msh_a, wle_a, mac_a, mclr_a, push_a, fl_a, busy_a, done_a};
  assign obs_b = {if_b.mem_rd, if_b.mem_wr, if_b.mem_addr_sel, if_b.addr_init,
                  if_b.addr_inc_img, if_b.addr_inc_filt, if_b.addr_inc_out,
                  fwe_b, fidx_b, widx_b,
                  mwe_b, msh_b, wle_b, mac_b, mclr_b, push_b, fl_b, busy_b, done_b};
  assign o = sel ? obs_b : obs_a;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // rmode: 0 = ready every cycle, 1 = ready one cycle in three, 2 = random.
  // abort_mac > 0 drops rst once that many MAC cycles have been seen.
  task automatic run_job(input bit use_b, input int rmode, input int abort_mac,
                         input string tag);
    int stride = use_b ? B_STRIDE : 1;
    int pack   = use_b ? B_PACK : 4;
    int rows   = use_b ? B_ROWS : 16;
    int wpr    = (LL - FL) / stride + 1;
    int pushes = wpr * NF * rows;
    int exp_fl = ((pushes % pack) != 0) ? 1 : 0;
    int cyc = 0;
    int n_filt = 0, n_incf = 0, n_main = 0, n_inci = 0, n_push = 0, n_mac = 0;
    int n_mclr = 0, n_wle = 0, n_shift = 0, n_wr = 0, n_fl = 0, n_out = 0;
    int n_init = 0, n_done = 0;
    bit fin = 0, seen_done = 0, prev_rd = 0, prev_wr = 0, prev_rdy = 0, last_busy = 0;
    bit st, rdy;
    logic [NF-1:0] exp_fwe;
    sel = use_b;
    while (!fin && cyc < 20000) begin
      @(negedge clk);
      st = (cyc < 3) || (last_busy && cyc >= 100 && cyc < 103);
      start_a = !use_b && st;
      start_b = use_b && st;
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = ($urandom_range(0, 2) == 0);
      endcase
      if_a.mem_ready = rdy;
      if_b.mem_ready = rdy;
      #1;
      if (prev_rd && !prev_rdy) check_val({tag, "_rd_hold"}, o.rd, 1);
      if (prev_wr && !prev_rdy) check_val({tag, "_wr_hold"}, o.wr, 1);
      if (o.ainit) n_init++;
      if (o.fwe != '0) begin
        exp_fwe = NF'(1) << (n_filt / FL);
        check_val({tag, "_filt_we"}, o.fwe, exp_fwe);
        check_val({tag, "_filt_word"}, o.widx, n_filt % FL);
        check_val({tag, "_filt_asel"}, o.asel, 1);
        n_filt++;
      end
      if (o.inc_filt) n_incf++;
      if (o.mwe) begin
        if (n_main == 0) check_val({tag, "_main_after_filt"}, n_filt, NF * FL);
        check_val({tag, "_main_asel"}, o.asel, 0);
        n_main++;
      end
      if (o.inc_img) n_inci++;
      if (o.mac) begin
        check_val({tag, "_mac_word"}, o.widx, n_mac % FL);
        n_mac++;
      end
      if (o.push) begin
        check_val({tag, "_push_filt"}, o.fidx, n_push % NF);
        n_push++;
      end
      if (o.mclr) n_mclr++;
      if (o.wle) n_wle++;
      if (o.msh) n_shift++;
      if (o.wr && rdy) begin
        if (o.fl) n_fl++;
        else n_wr++;
      end
      if (o.inc_out) n_out++;
      if (o.done) n_done++;
      if (abort_mac > 0 && n_mac == abort_mac) begin
        rst = 1'b0;
        $display("job %s: reset after %0d mac cycles at cycle %0d", tag, n_mac, cyc);
        return;
      end
      if (seen_done) begin
        check_val({tag, "_idle_busy"}, o.busy, 0);
        check_val({tag, "_idle_done"}, o.done, 0);
        fin = 1;
      end else if (o.done) begin
        seen_done = 1;
      end
      prev_rd   = o.rd;
      prev_wr   = o.wr;
      prev_rdy  = rdy;
      last_busy = o.busy;
      cyc++;
    end
    check_val({tag, "_finished"}, fin, 1);
    check_val({tag, "_filt_acc"}, n_filt, NF * FL);
    check_val({tag, "_inc_filt"}, n_incf, NF * FL);
    check_val({tag, "_main_acc"}, n_main, NL * LL + (rows - 1) * LL);
    check_val({tag, "_inc_img"}, n_inci, NL * LL + (rows - 1) * LL);
    check_val({tag, "_pushes"}, n_push, pushes);
    check_val({tag, "_mac"}, n_mac, pushes * FL);
    check_val({tag, "_mac_clr"}, n_mclr, pushes);
    check_val({tag, "_win_load"}, n_wle, wpr * rows);
    check_val({tag, "_shift"}, n_shift, (NL - 1) + (rows - 1));
    check_val({tag, "_writes"}, n_wr, pushes / pack);
    check_val({tag, "_flush_wr"}, n_fl, exp_fl);
    check_val({tag, "_inc_out"}, n_out, pushes / pack + exp_fl);
    check_val({tag, "_addr_init"}, n_init, 1);
    check_val({tag, "_done"}, n_done, 1);
    $display("job %s: cycles=%0d pushes=%0d writes=%0d flush=%0d", tag, cyc, n_push, n_wr, n_fl);
  endtask

  initial begin
    rst = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    sel = 1'b0;
    if_a.mem_ready = 1'b1;
    if_b.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_val("reset_a", obs_a, 0);
    check_val("reset_b", obs_b, 0);
    @(negedge clk);
    rst = 1'b1;

    run_job(1'b0, 0, 0, "dflt_rdy1");
    run_job(1'b0, 1, 0, "dflt_rdy3");

    run_job(1'b0, 0, $urandom_range(1, 200), "abort");
    @(negedge clk);
    rst = 1'b1;
    start_a = 1'b0;
    if_a.mem_ready = 1'b1;
    #1;
    check_val("abort_outputs", obs_a, 0);
    check_val("abort_busy", busy_a, 0);

    run_job(1'b0, 2, 0, "dflt_rand");
    run_job(1'b1, 0, 0, "s2p3_rdy1");
    run_job(1'b1, 2, 0, "s2p3_rand");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
